// File: rtl/uart.sv
// Full-duplex UART: independent TX and RX state machines on one clock.
// Each line bit lasts CPB = CLK_FREQ/BAUD clocks. There is no parity.
// TX sends STOP_BITS stop bits. RX checks a single stop bit and
// strobes data_out_valid for one cycle on each good frame.
module uart #(
  parameter int BAUD      = 115200,
  parameter int CLK_FREQ  = 100000000,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  output logic                 serial_data_out,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 tx_ready
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t            tx_state_reg;
  logic [CW-1:0]        tx_cnt_reg;
  logic [BW-1:0]        tx_bit_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_stop_reg;

  // TX state machine. The line and tx_ready are driven straight from
  // registers. The word is latched at accept time, so later changes on
  // data_in cannot disturb a frame that is already being sent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_reg    <= TX_IDLE;
      tx_cnt_reg      <= '0;
      tx_bit_reg      <= '0;
      tx_shift_reg    <= '0;
      tx_stop_reg     <= 1'b0;
      serial_data_out <= 1'b1;
      tx_ready        <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          serial_data_out <= 1'b1;
          tx_ready        <= 1'b1;
          tx_cnt_reg      <= '0;
          if (tx_ready && data_in_valid) begin
            tx_shift_reg    <= data_in;
            tx_ready        <= 1'b0;
            serial_data_out <= 1'b0;
            tx_state_reg    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg      <= '0;
            tx_bit_reg      <= '0;
            serial_data_out <= tx_shift_reg[0];
            tx_shift_reg    <= tx_shift_reg >> 1;
            tx_state_reg    <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == DATA_LAST) begin
              serial_data_out <= 1'b1;
              tx_stop_reg     <= 1'b0;
              tx_state_reg    <= TX_STOP;
            end else begin
              serial_data_out <= tx_shift_reg[0];
              tx_shift_reg    <= tx_shift_reg >> 1;
              tx_bit_reg      <= tx_bit_reg + 1'b1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_stop_reg == STOP_LAST) begin
              tx_ready     <= 1'b1;
              tx_state_reg <= TX_IDLE;
            end else begin
              tx_stop_reg <= 1'b1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  logic [1:0]           rx_sync_reg;
  logic                 rx_prev_reg;
  logic                 rx_bit;
  rx_state_t            rx_state_reg;
  logic [CW-1:0]        rx_cnt_reg;
  logic [BW-1:0]        rx_bit_cnt_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;

  assign rx_bit = rx_sync_reg[1];

  // Two-flop synchroniser for the asynchronous line. The extra flop keeps
  // the previous synchronised value so a falling edge can be detected.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sync_reg <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], serial_data_in};
      rx_prev_reg <= rx_sync_reg[1];
    end
  end

  // RX state machine. It samples mid-bit, starting from half a bit after
  // the start edge. A start bit that is high again at mid-bit is treated
  // as a glitch. A low stop bit drops the word and waits for the idle line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_cnt_reg <= '0;
      rx_shift_reg   <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          rx_cnt_reg <= '0;
          if (rx_prev_reg && !rx_bit) rx_state_reg <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg     <= '0;
            rx_bit_cnt_reg <= '0;
            rx_state_reg   <= rx_bit ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_bit, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_bit_cnt_reg == DATA_LAST) rx_state_reg <= RX_STOP;
            else rx_bit_cnt_reg <= rx_bit_cnt_reg + 1'b1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg <= '0;
            if (rx_bit) begin
              data_out       <= rx_shift_reg;
              data_out_valid <= 1'b1;
              rx_state_reg   <= RX_IDLE;
            end else begin
              rx_state_reg <= RX_WAIT_IDLE;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_bit) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Testbench for uart. It uses three instance groups:
// - a default-rate instance for the exact TX line-timing checks,
// - a fast TX->RX pair for the loopback streams (CPB=17, truncated),
// - a CPB=256 receiver driven bit by bit for the glitch and
//   framing-error cases.
module tb_uart;

  localparam int CPB_A = 100000000 / 115200;  // 868
  localparam int CPB_F = 1750000 / 100000;    // 17
  localparam int CPB_G = 25600000 / 100000;   // 256

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default-rate instance
  logic       a_rxd;
  logic [7:0] a_din;
  logic       a_dv;
  logic [7:0] a_dout;
  logic       a_dov, a_line, a_tx_ready;

  // fast loopback pair
  logic       f_idle_in;
  logic [7:0] f_din, f_rx_din;
  logic       f_dv, f_rx_dv;
  logic [7:0] f_tx_dout, f_dout;
  logic       f_tx_dov, f_dov, f_line, f_rx_line, f_tx_ready, f_rx_ready;

  // bit-banged receiver
  logic       g_line;
  logic [7:0] g_din;
  logic       g_dv;
  logic [7:0] g_dout;
  logic       g_dov, g_txline, g_ready;

  uart dut_a (
    .clk(clk), .rstn(rstn), .serial_data_in(a_rxd),
    .data_out(a_dout), .data_out_valid(a_dov), .serial_data_out(a_line),
    .data_in(a_din), .data_in_valid(a_dv), .tx_ready(a_tx_ready)
  );

  uart #(.BAUD(100000), .CLK_FREQ(1750000)) f_tx (
    .clk(clk), .rstn(rstn), .serial_data_in(f_idle_in),
    .data_out(f_tx_dout), .data_out_valid(f_tx_dov), .serial_data_out(f_line),
    .data_in(f_din), .data_in_valid(f_dv), .tx_ready(f_tx_ready)
  );

  uart #(.BAUD(100000), .CLK_FREQ(1750000)) f_rx (
    .clk(clk), .rstn(rstn), .serial_data_in(f_line),
    .data_out(f_dout), .data_out_valid(f_dov), .serial_data_out(f_rx_line),
    .data_in(f_rx_din), .data_in_valid(f_rx_dv), .tx_ready(f_rx_ready)
  );

  uart #(.BAUD(100000), .CLK_FREQ(25600000)) g_dut (
    .clk(clk), .rstn(rstn), .serial_data_in(g_line),
    .data_out(g_dout), .data_out_valid(g_dov), .serial_data_out(g_txline),
    .data_in(g_din), .data_in_valid(g_dv), .tx_ready(g_ready)
  );

  // Counts every cycle that g_dut's strobe is high.
  int g_pulses = 0;
  always @(negedge clk) if (g_dov === 1'b1) g_pulses <= g_pulses + 1;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Waits for tx_ready, then presents one word for exactly one accept edge.
  task automatic start_a(input logic [7:0] d);
    int guard;
    guard = 0;
    while (a_tx_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    chk("a_ready_before_send", a_tx_ready, 1);
    a_din = d;
    a_dv  = 1'b1;
    @(negedge clk);
    a_dv  = 1'b0;
    a_din = ~d;  // must not leak into the frame in flight
  endtask

  // Expected frame: start 0, data LSB first, stop 1, with each bit held
  // CPB_A clocks. tx_ready stays low for the full 10*CPB_A clocks.
  task automatic send_a(input logic [7:0] d, input string tag);
    int   bad;
    logic expb;
    start_a(d);
    for (int b = 0; b < 10; b++) begin
      bad  = 0;
      expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      for (int c = 0; c < CPB_A; c++) begin
        if (a_line !== expb || a_tx_ready !== 1'b0) bad++;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, b), bad, 0);
    end
    chk({tag, "_ready_back"}, a_tx_ready, 1);
    chk({tag, "_line_idle"}, a_line, 1);
    $display("tx frame %s data=%02h", tag, d);
  endtask

  // Bit-bangs one frame onto g_line. The stop-bit level is chosen by the caller.
  task automatic g_frame(input logic [7:0] d, input logic stop);
    for (int b = 0; b < 10; b++) begin
      g_line = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
      repeat (CPB_G) @(negedge clk);
    end
    g_line = 1'b1;
  endtask

  // Streams src_q through the fast pair and expects the same bytes in order.
  task automatic run_stream(input bit gaps, input string tag);
    int n, limit;
    n     = src_q.size();
    limit = n * 14 * CPB_F + 500;
    exp_q = src_q;
    fork
      begin
        int guard;
        for (int i = 0; i < n; i++) begin
          if (gaps) begin f_dv = 1'b0; repeat ($urandom_range(0, 3)) @(negedge clk); end
          f_din = src_q[i];
          f_dv  = 1'b1;
          guard = 0;
          while (f_tx_ready !== 1'b1 && guard < limit) begin @(negedge clk); guard++; end
          @(posedge clk);
          #1;
        end
        f_dv = 1'b0;
      end
      begin
        int got, cyc;
        logic [7:0] want;
        got = 0;
        cyc = 0;
        while (got < n && cyc < limit) begin
          @(negedge clk);
          cyc++;
          if (f_dov === 1'b1) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk($sformatf("%s_word%0d", tag, got), f_dout, want);
            $display("rx %s word %0d data=%02h expected=%02h", tag, got, f_dout, want);
            got++;
          end
        end
        chk({tag, "_count"}, got, n);
      end
    join
    begin
      int extra;
      extra = 0;
      repeat (CPB_F * 20) begin @(negedge clk); if (f_dov === 1'b1) extra++; end
      chk({tag, "_no_extra"}, extra, 0);
    end
  endtask

  initial begin
    int p0;
    rstn = 1'b0;
    a_rxd = 1'b1; a_din = '0; a_dv = 1'b0;
    f_idle_in = 1'b1; f_din = '0; f_dv = 1'b0; f_rx_din = '0; f_rx_dv = 1'b0;
    g_line = 1'b1; g_din = '0; g_dv = 1'b0;

    // reset state
    #47;
    chk("rst_line", a_line, 1);
    chk("rst_tx_ready", a_tx_ready, 0);
    chk("rst_data_out", a_dout, 0);
    chk("rst_valid", a_dov, 0);
    chk("rst_f_data_out", f_dout, 0);
    #3 rstn = 1'b1;
    #2 chk("rel_tx_ready_low", a_tx_ready, 0);
    @(negedge clk);
    chk("rel_tx_ready_high", a_tx_ready, 1);
    chk("rel_line", a_line, 1);

    // single frame at the default rate
    send_a(8'h49, "f49");

    // reset during the data bits; 0x3C drives d1=0 in bit period 2
    start_a(8'h3C);
    repeat (CPB_A * 2 + 200) @(negedge clk);
    chk("mid_line_low", a_line, 0);
    #3 rstn = 1'b0;
    #1;
    chk("mid_rst_line", a_line, 1);
    chk("mid_rst_ready", a_tx_ready, 0);
    #40;
    chk("mid_rst_line_hold", a_line, 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_a(8'hFF, "fFF");

    // glitch rejection, then a good frame
    p0 = g_pulses;
    g_line = 1'b0;
    repeat (100) @(negedge clk);
    g_line = 1'b1;
    repeat (3 * CPB_G) @(negedge clk);
    chk("glitch_no_strobe", g_pulses - p0, 0);
    p0 = g_pulses;
    g_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    chk("glitch_next_strobes", g_pulses - p0, 1);
    chk("glitch_next_data", g_dout, 8'hA5);
    $display("rx g frame data=%02h", g_dout);

    // framing error, then a good frame
    p0 = g_pulses;
    g_frame(8'h3C, 1'b0);
    repeat (CPB_G) @(negedge clk);
    chk("ferr_no_strobe", g_pulses - p0, 0);
    chk("ferr_data_hold", g_dout, 8'hA5);
    p0 = g_pulses;
    g_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk("ferr_next_strobes", g_pulses - p0, 1);
    chk("ferr_next_data", g_dout, 8'h5A);
    $display("rx g frame data=%02h", g_dout);

    // directed loopback, data_in_valid held high
    src_q = '{8'h49, 8'h41, 8'h4E, 8'h20, 8'h4D, 8'h55, 8'h52, 8'h50, 8'h48, 8'h59,
              8'h20, 8'h57, 8'h41, 8'h53, 8'h20, 8'h48, 8'h45, 8'h52, 8'h45};
    run_stream(1'b0, "loop");

    // random loopback with random valid gaps
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom_range(0, 255)));
    run_stream(1'b1, "rand");

    // untouched halves stay idle
    chk("idle_f_rx_line", f_rx_line, 1);
    chk("idle_g_txline", g_txline, 1);
    chk("idle_f_tx_valid", f_tx_dov, 0);
    chk("idle_f_tx_dout", f_tx_dout, 0);
    chk("idle_a_dout", a_dout, 0);
    chk("idle_a_valid", a_dov, 0);
    chk("idle_g_ready", g_ready, 1);
    chk("idle_f_rx_ready", f_rx_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
